// File: rtl/cfir_decim2.sv
// -----------------------------------------------------------------------------
// cfir_decim2
// Compensating FIR, decimate-by-2, placed after the variable-rate CIC.
// One signed sample is accepted per in_strobe, and every second sample
// starts a TAPS-tap convolution. A single time-shared multiply-accumulate
// performs the convolution. Coefficients are loadable at run time, so the
// droop correction can track the CIC decimation setting.
//
// Ports
//   clock       single clock domain
//   reset_n     asynchronous active-low reset
//   in_strobe   one-cycle pulse, in_data valid
//   in_data     signed input sample (IN_WIDTH)
//   coef_we     coefficient write enable (honoured only in CLEAR/IDLE)
//   coef_addr   coefficient index k
//   coef_data   signed Q1.17 coefficient value
//   ready       high once the sample buffer has been zeroed after reset
//   out_strobe  one-cycle pulse, out_data is new
//   out_data    signed filtered, decimated sample (OUT_WIDTH)
//   overrun     sticky, a computation trigger arrived while busy
// -----------------------------------------------------------------------------
module cfir_decim2 #(
  parameter int TAPS       = 64,
  parameter int IN_WIDTH   = 27,
  parameter int COEF_WIDTH = 18,
  parameter int OUT_WIDTH  = 24
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          in_strobe,
  input  logic signed [IN_WIDTH-1:0]    in_data,
  input  logic                          coef_we,
  input  logic [$clog2(TAPS)-1:0]       coef_addr,
  input  logic signed [COEF_WIDTH-1:0]  coef_data,
  output logic                          ready,
  output logic                          out_strobe,
  output logic signed [OUT_WIDTH-1:0]   out_data,
  output logic                          overrun
);

  localparam int AW    = $clog2(TAPS);
  localparam int BW    = AW + 1;              // sample buffer address width
  localparam int DEPTH = 2 * TAPS;
  localparam int PW    = IN_WIDTH + COEF_WIDTH;
  localparam int ACW   = PW + AW;

  // Rounding constant 2^(COEF_WIDTH-2) and saturation limits, all ACW+1 wide.
  localparam logic signed [ACW:0] RND_C =
    {{(ACW-COEF_WIDTH+2){1'b0}}, 1'b1, {(COEF_WIDTH-2){1'b0}}};
  localparam logic signed [ACW:0] SAT_MAX_C =
    {{(ACW-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACW:0] SAT_MIN_C =
    {{(ACW-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_IDLE  = 2'd1,
    S_MAC   = 2'd2,
    S_ROUND = 2'd3
  } state_e;

  // Control state
  state_e                 state_q, state_d;
  logic [BW-1:0]          wp_q, wp_d;
  logic                   phase_q, phase_d;
  logic [BW-1:0]          base_q, base_d;
  logic [BW-1:0]          cnt_q, cnt_d;
  logic                   ready_q, ready_d;
  logic                   overrun_q, overrun_d;
  logic                   out_strobe_q, out_strobe_d;
  logic signed [OUT_WIDTH-1:0] out_data_q, out_data_d;

  // MAC pipeline: read stage, product stage, accumulator
  logic                         rd_vld_q, rd_vld_d;
  logic signed [COEF_WIDTH-1:0] coef_rd_q, coef_rd_d;
  logic signed [IN_WIDTH-1:0]   smp_rd_q, smp_rd_d;
  logic                         prod_vld_q, prod_vld_d;
  logic signed [PW-1:0]         prod_q, prod_d;
  logic signed [ACW-1:0]        acc_q, acc_d;

  // Storage (not reset; the sample buffer is zeroed by the CLEAR state)
  logic signed [IN_WIDTH-1:0]   smp_mem_q  [DEPTH];
  logic signed [COEF_WIDTH-1:0] coef_mem_q [TAPS];

  logic                         smp_we_s;
  logic                         trig_s;
  logic                         start_s;
  logic                         coef_wr_s;
  logic [BW-1:0]                rd_addr_s;
  logic signed [ACW:0]          acc_rnd_s;
  logic signed [ACW:0]          acc_shr_s;
  logic signed [OUT_WIDTH-1:0]  y_s;

  // Qualify strobes and address generation.
  always_comb begin
    smp_we_s  = ready_q & in_strobe;
    trig_s    = smp_we_s & phase_q;
    start_s   = trig_s & (state_q == S_IDLE);
    coef_wr_s = coef_we & ((state_q == S_IDLE) | (state_q == S_CLEAR));
    // Newest sample first: tap k reads base-k, wrapping in the 2*TAPS buffer.
    rd_addr_s = base_q - cnt_q;
  end

  // Round half up and saturate the accumulator to the output range.
  always_comb begin
    acc_rnd_s = {acc_q[ACW-1], acc_q} + RND_C;
    acc_shr_s = acc_rnd_s >>> (COEF_WIDTH - 1);
    if (acc_shr_s > SAT_MAX_C) begin
      y_s = SAT_MAX_C[OUT_WIDTH-1:0];
    end else if (acc_shr_s < SAT_MIN_C) begin
      y_s = SAT_MIN_C[OUT_WIDTH-1:0];
    end else begin
      y_s = acc_shr_s[OUT_WIDTH-1:0];
    end
  end

  // Control next-state: clear sweep, trigger acceptance, MAC sequencing, output.
  always_comb begin
    state_d      = state_q;
    wp_d         = wp_q;
    phase_d      = phase_q;
    base_d       = base_q;
    cnt_d        = cnt_q;
    ready_d      = ready_q;
    overrun_d    = overrun_q;
    out_strobe_d = 1'b0;
    out_data_d   = out_data_q;

    case (state_q)
      S_CLEAR: begin
        // wp doubles as the clear index; it wraps back to 0 when done.
        wp_d = wp_q + BW'(1);
        if (wp_q == BW'(DEPTH - 1)) begin
          ready_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_CLEAR;
        end
      end
      S_IDLE: begin
        if (trig_s) begin
          state_d = S_MAC;
          base_d  = wp_q;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MAC: begin
        // TAPS read cycles plus two cycles to drain product and accumulator.
        cnt_d = cnt_q + BW'(1);
        if (cnt_q == BW'(TAPS + 1)) begin
          state_d = S_ROUND;
        end else begin
          state_d = S_MAC;
        end
      end
      S_ROUND: begin
        out_strobe_d = 1'b1;
        out_data_d   = y_s;
        state_d      = S_IDLE;
      end
      default: begin
        state_d = S_CLEAR;
      end
    endcase

    // Sample writes are only possible once ready, so they never collide
    // with the clear sweep's use of wp.
    if (smp_we_s) begin
      wp_d    = wp_q + BW'(1);
      phase_d = ~phase_q;
    end else begin
      phase_d = phase_q;
    end

    if (trig_s && (state_q != S_IDLE)) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = overrun_d;
    end
  end

  // MAC datapath next-state.
  always_comb begin
    rd_vld_d   = (state_q == S_MAC) && (cnt_q < BW'(TAPS));
    coef_rd_d  = coef_mem_q[cnt_q[AW-1:0]];
    smp_rd_d   = smp_mem_q[rd_addr_s];
    prod_vld_d = rd_vld_q;
    prod_d     = PW'(coef_rd_q) * PW'(smp_rd_q);
    if (start_s) begin
      acc_d = '0;
    end else if (prod_vld_q) begin
      acc_d = acc_q + ACW'(prod_q);
    end else begin
      acc_d = acc_q;
    end
  end

  // Control and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_CLEAR;
      wp_q         <= '0;
      phase_q      <= 1'b0;
      base_q       <= '0;
      cnt_q        <= '0;
      ready_q      <= 1'b0;
      overrun_q    <= 1'b0;
      out_strobe_q <= 1'b0;
      out_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      wp_q         <= wp_d;
      phase_q      <= phase_d;
      base_q       <= base_d;
      cnt_q        <= cnt_d;
      ready_q      <= ready_d;
      overrun_q    <= overrun_d;
      out_strobe_q <= out_strobe_d;
      out_data_q   <= out_data_d;
    end
  end

  // MAC pipeline registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_vld_q   <= 1'b0;
      coef_rd_q  <= '0;
      smp_rd_q   <= '0;
      prod_vld_q <= 1'b0;
      prod_q     <= '0;
      acc_q      <= '0;
    end else begin
      rd_vld_q   <= rd_vld_d;
      coef_rd_q  <= coef_rd_d;
      smp_rd_q   <= smp_rd_d;
      prod_vld_q <= prod_vld_d;
      prod_q     <= prod_d;
      acc_q      <= acc_d;
    end
  end

  // Sample buffer write port: zeros during clear, samples once ready.
  always_ff @(posedge clock) begin
    if (state_q == S_CLEAR) begin
      smp_mem_q[wp_q] <= '0;
    end else if (smp_we_s) begin
      smp_mem_q[wp_q] <= in_data;
    end
  end

  // Coefficient write port, locked out while a computation is in flight.
  always_ff @(posedge clock) begin
    if (coef_wr_s) begin
      coef_mem_q[coef_addr] <= coef_data;
    end
  end

  assign ready      = ready_q;
  assign out_strobe = out_strobe_q;
  assign out_data   = out_data_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_cfir_decim2.sv
// -----------------------------------------------------------------------------
// tb_cfir_decim2
// Directed stimulus with hand-computed expectations. Each accepted trigger
// pushes its expected output and trigger cycle into a queue; an independent
// monitor pops on every out_strobe and checks value and latency.
// -----------------------------------------------------------------------------
module tb_cfir_decim2;

  localparam int TAPS    = 64;
  localparam int LAT     = TAPS + 3;

  logic               clock;
  logic               reset_n;
  logic               in_strobe;
  logic signed [26:0] in_data;
  logic               coef_we;
  logic [5:0]         coef_addr;
  logic signed [17:0] coef_data;
  logic               ready;
  logic               out_strobe;
  logic signed [23:0] out_data;
  logic               overrun;

  cfir_decim2 dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_strobe  (in_strobe),
    .in_data    (in_data),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_data  (coef_data),
    .ready      (ready),
    .out_strobe (out_strobe),
    .out_data   (out_data),
    .overrun    (overrun)
  );

  typedef struct {
    int val;
    int tc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_acc = -1000;
  logic ovr_exp = 1'b0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Free-running edge counter used to measure latency.
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: every out_strobe must match the oldest expectation.
  always @(negedge clock) begin
    if (reset_n && out_strobe) begin
      if (q.size() == 0) begin
        chk("unexpected_strobe", 1, 0);
      end else begin
        mon_e = q.pop_front();
        chk("out_data", out_data, mon_e.val);
        chk("latency", cyc - mon_e.tc, LAT);
      end
    end
  end

  function automatic int coef_val(input int mode, input int k);
    case (mode)
      0: return (k == 0) ? 1 : 0;
      1: return k + 1;
      2: return 131071;
      default: return (k == 0) ? 65536 : 0;
    endcase
  endfunction

  task automatic load_all(input int mode);
    for (int k = 0; k < TAPS; k++) begin
      @(negedge clock);
      coef_we   = 1'b1;
      coef_addr = 6'(k);
      coef_data = 18'(coef_val(mode, k));
    end
    @(negedge clock);
    coef_we = 1'b0;
  endtask

  task automatic poke_coef(input int k, input int v);
    @(negedge clock);
    coef_we   = 1'b1;
    coef_addr = 6'(k);
    coef_data = 18'(v);
    @(negedge clock);
    coef_we = 1'b0;
  endtask

  // One sample; 'gap' clocks until the next send. A trigger is predicted to
  // be accepted only if it falls outside the previous busy window.
  task automatic send(input int x, input bit trig, input int expv, input int gap);
    int   tc;
    exp_t e;
    @(negedge clock);
    in_strobe = 1'b1;
    in_data   = 27'(x);
    tc = cyc + 1;
    if (trig) begin
      if (tc - last_acc > LAT) begin
        last_acc = tc;
        e.val = expv;
        e.tc  = tc;
        q.push_back(e);
      end else begin
        ovr_exp = 1'b1;
      end
    end
    @(negedge clock);
    in_strobe = 1'b0;
    chk("overrun", overrun, ovr_exp);
    repeat (gap - 2) @(negedge clock);
  endtask

  // Release reset (expected low on entry) and check the clear sweep.
  task automatic check_clear();
    reset_n = 1'b1;
    for (int k = 1; k <= 140; k++) begin
      @(negedge clock);
      chk("ready_rise", ready, (k >= 128) ? 1 : 0);
      chk("clear_strobe", out_strobe, 0);
      chk("clear_data", out_data, 0);
      chk("clear_overrun", overrun, 0);
      if (k == 9) begin
        in_strobe = 1'b1;
        in_data   = 27'(12345);
      end else begin
        in_strobe = 1'b0;
      end
    end
    last_acc = -1000;
    ovr_exp  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("rst_ready", ready, 0);
    chk("rst_strobe", out_strobe, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_data", out_data, 0);
    q.delete();
    repeat (3) @(negedge clock);
    check_clear();
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 400) begin
      @(negedge clock);
      n++;
    end
    chk("drain_pending", q.size(), 0);
    q.delete();
    repeat (2) @(negedge clock);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    in_strobe = 1'b0;
    in_data   = '0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    repeat (3) @(negedge clock);

    // Reset/clear, including a strobe during CLEAR that must be ignored.
    check_clear();

    // Rounding boundaries with coef[0]=1; the first sample after ready is
    // phase 0, which also shows the CLEAR-time strobe did not toggle phase.
    load_all(0);
    send(0,       0, 0,  40);
    send(65536,   1, 1,  40);
    send(0,       0, 0,  40);
    send(65535,   1, 0,  40);
    send(0,       0, 0,  40);
    send(-65536,  1, 0,  40);
    send(0,       0, 0,  40);
    send(-65537,  1, -1, 40);
    drain();

    // Impulse: coef[k]=k+1, outputs 2,4,...,64 then zeros. Coefficient
    // writes during the first MAC must be ignored.
    do_reset();
    load_all(1);
    for (int i = 0; i < 68; i++) begin
      int j;
      j = (i - 1) / 2;
      if (i == 1) begin
        send(0, 1, 2, 2);
        poke_coef(3, 77);
        poke_coef(63, -5);
        repeat (34) @(negedge clock);
      end else begin
        send((i == 0) ? 131072 : 0, (i % 2) == 1, (j < 32) ? 2 * (j + 1) : 0, 40);
      end
    end
    drain();

    // Saturation, positive then negative full scale.
    do_reset();
    load_all(2);
    for (int i = 0; i < 4; i++) send(8388607, (i % 2) == 1, 8388607, 40);
    drain();
    do_reset();
    for (int i = 0; i < 4; i++) send(-8388608, (i % 2) == 1, -8388608, 40);
    drain();

    // Overrun: 20-clock spacing drops every other trigger; the flag sticks
    // after spacing returns to 40. coef[0]=0.5 gives y=(x+1)/2.
    do_reset();
    load_all(3);
    for (int i = 0; i < 20; i++) begin
      send(1000 * i, (i % 2) == 1, 500 * i, (i < 12) ? 20 : 40);
    end
    chk("overrun_sticky", overrun, 1);
    drain();

    // Reset mid-MAC: no output, clear restarts, then normal operation.
    do_reset();
    send(10, 0, 0, 2);
    send(20, 0, 0, 20);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("midmac_ready", ready, 0);
    chk("midmac_strobe", out_strobe, 0);
    repeat (3) @(negedge clock);
    check_clear();
    send(10,   0, 0,    40);
    send(4000, 1, 2000, 40);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cfir_decim2.md
# cfir_decim2

Compensating FIR decimate-by-2 stage directly downstream of the variable-rate CIC decimator. Accepts one signed sample per `in_strobe` (the CIC's `out_data`/`out_strobe`) and computes one TAPS-tap FIR output for every second input sample. A single time-shared multiply-accumulate does the work. Coefficients are run-time loadable, so the CIC droop correction can follow the CIC decimation setting.

## Interface
- TAPS, 64: filter length; power of 2, 8..256.
- IN_WIDTH, 27: input sample width, signed; matches CIC OUT_WIDTH.
- COEF_WIDTH, 18: coefficient width, signed Q1.17.
- OUT_WIDTH, 24: output sample width, signed.

Ports:
- clock  in  1  single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- in_strobe  in  1  one-cycle pulse; in_data valid.
- in_data  in  IN_WIDTH  signed input sample.
- coef_we  in  1  coefficient write enable.
- coef_addr  in  log2(TAPS)  coefficient index k.
- coef_data  in  COEF_WIDTH  coefficient value.
- ready  out  1  high once the sample buffer is cleared after reset.
- out_strobe  out  1  one-cycle pulse; out_data is new.
- out_data  out  OUT_WIDTH  signed filtered, decimated sample.
- overrun  out  1  sticky; a computation trigger was dropped.

## Operation
- **Reset (async):**
  - out_strobe=0, out_data=0, overrun=0, ready=0.
  - Write pointer=0, phase=0, state=CLEAR.
  - The coefficient RAM is not reset.
- **CLEAR:**
  - Writes zeros to all 2*TAPS sample-buffer entries, one per clock, over 2*TAPS clocks.
  - Then ready=1 and state=IDLE.
  - in_strobe during CLEAR is ignored: no write, no phase change.
- **Sample write:**
  - Applies to every in_strobe while ready=1, in any state.
  - Writes in_data to buffer[wp]; wp increments modulo 2*TAPS.
  - phase toggles.
  - The buffer is 2*TAPS deep, so writes during MAC never overwrite samples being read.
- **Trigger:**
  - Condition: in_strobe with phase==1 (second sample of each pair; the first sample after ready is phase 0).
  - If state is IDLE: latch base=that sample's address and go to MAC.
  - Otherwise: overrun=1 (sticky until reset), and no output for that trigger.
- **MAC:**
  - Runs TAPS cycles. In cycle k: acc += coef[k] * buffer[base-k mod 2*TAPS].
  - The multiplier output is registered (one pipeline stage).
  - Full precision throughout: product IN_WIDTH+COEF_WIDTH bits; accumulator IN_WIDTH+COEF_WIDTH+log2(TAPS) bits, cleared at MAC start.
  - After the MAC, state=ROUND.
- **ROUND:**
  - y = (acc + 2^(COEF_WIDTH-2)) >>> (COEF_WIDTH-1), i.e. round half up.
  - Saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - Register the result to out_data, pulse out_strobe, then state=IDLE.
  - out_data holds its value between strobes.
- **Coefficient writes:**
  - coef_we while state is IDLE or CLEAR: coef[coef_addr]=coef_data on that clock edge.
  - coef_we while MAC or ROUND: ignored.
- **Reset mid-operation:** the computation in flight is abandoned, no out_strobe, and the block restarts in CLEAR.

## Timing
- Latency: out_strobe rises exactly TAPS+3 clocks after the edge that samples the triggering in_strobe.
  - Edge t: trigger latched.
  - Edges t+1..t+TAPS: coefficient/sample reads.
  - Edge t+TAPS+1: last product registered.
  - Edge t+TAPS+2: accumulate complete.
  - Edge t+TAPS+3: out_data/out_strobe registered.
- Busy window: edges t+1 through t+TAPS+3. A trigger sampled in that window is dropped.
- A trigger on the edge right after the out_strobe edge is accepted.
- Sustained throughput requires in_strobe spacing ≥ ceil((TAPS+4)/2) clocks. Any spacing ≥ 1 is tolerated for sample writes.
- ready rises 2*TAPS clocks after reset_n deasserts. out_strobe is never asserted before then.
- in_strobe and coef_we in the same cycle are independent.

## Test plan
- **Reset/clear:**
  - Stimulus: release reset_n; pulse in_strobe at cycle 10.
  - Required: ready=1 exactly 128 clocks after release; out_data=0, out_strobe=0, overrun=0 throughout; the cycle-10 sample is not written.
- **Impulse:**
  - Stimulus: load coef[k]=k+1; feed 131072 then zeros at 40-clock spacing.
  - Required: 32 outputs of 2,4,6,…,64, then zeros; each out_strobe exactly 67 clocks after its trigger.
- **Rounding:**
  - Stimulus: coef[0]=1, other taps 0; feed pairs (0,65536) then (0,-65536).
  - Required: out_data=1, then 0.
- **Saturation:**
  - Stimulus: all coef=131071; constant input 8388607, then constant input -8388608.
  - Required: out_data=8388607, then -8388608.
- **Overrun:**
  - Stimulus: in_strobe every 20 clocks, TAPS=64.
  - Required: overrun=1 at the second trigger; out_strobe every 80 clocks; overrun stays 1 when spacing returns to 40.
- **Write-while-busy and reset mid-MAC:**
  - coef_we during MAC: no coefficient change; impulse output unchanged.
  - reset_n low at trigger+20: no out_strobe, ready=0, CLEAR restarts.
